// File: rtl/mioc_pkg.sv
// Shared MIOC definitions: DRAM scheduler state encoding and default refresh geometry.
package mioc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ROW,
        ST_COL,
        ST_HOLD,
        ST_PRE,
        ST_RFSH,
        ST_BREQ,
        ST_DOWN,
        ST_DRFSH,
        ST_DPRE,
        ST_BREL
    } sched_state_t;

    localparam int DEFAULT_REFRESH_PERIOD = 54;
    localparam int REF_ROW_BITS           = 7;

    // States belonging to a strobed memory/refresh cycle that returns to a saved state
    function automatic logic is_access_state(input sched_state_t s);
        return s inside {ST_ROW, ST_COL, ST_HOLD, ST_PRE, ST_RFSH};
    endfunction

endpackage

// File: rtl/mioc_sync2.sv
// Two-flop synchronizer for asynchronous MIOC inputs; RESET_VAL matches the input's idle level.
module mioc_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mioc_dram_sched.sv
// DRAM cycle sequencer and Z80/6801 bus arbiter for the MIOC.
// Define MIOC_DMA_REFRESH_EN to build the internal refresh timer, DRFSH/DPRE cycles and REF_ROW.
module mioc_dram_sched
    import mioc_pkg::*;
#(
    parameter int REFRESH_PERIOD = DEFAULT_REFRESH_PERIOD,
    parameter int ROW_BITS       = REF_ROW_BITS
) (
    input  logic                B_PHI,
    input  logic                RST_N,
    input  logic                BMREQ_N,
    input  logic                BRD_N,
    input  logic                N_BWR,
    input  logic                BRFSH_N,
    input  logic                BA15,
    input  logic                RAM_LO_EN,
    input  logic                RAM_HI_EN,
    input  logic                DMA_N,
    input  logic                BUSAK_N,
    output logic                RAS_N,
    output logic                CAS1_N,
    output logic                CAS2_N,
    output logic                MUX,
    output logic                BUSRQ_N,
    output logic                ADDRBUFEN_N,
    output logic                REF_OE,
    output logic [ROW_BITS-1:0] REF_ROW,
    output logic                BUSY
);

    sched_state_t state, next_state;
    sched_state_t ret_state, next_ret;
    logic dma_n_sync, dma_req;
    logic bank, rfsh_cnt, refresh_due;
    logic z80_rfsh, mem_acc;

    mioc_sync2 #(.RESET_VAL(1'b1)) u_dma_sync (
        .clk   (B_PHI),
        .rst_n (RST_N),
        .d     (DMA_N),
        .q     (dma_n_sync)
    );

    assign dma_req  = ~dma_n_sync;
    assign z80_rfsh = !BMREQ_N && !BRFSH_N;
    assign mem_acc  = !BMREQ_N && BRFSH_N && (!BRD_N || !N_BWR) && (BA15 ? RAM_HI_EN : RAM_LO_EN);

    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            ret_state <= ST_IDLE;
            bank      <= 1'b0;
            rfsh_cnt  <= 1'b0;
        end else begin
            state     <= next_state;
            ret_state <= next_ret;
            if (state == ST_ROW)
                bank <= BA15;
            rfsh_cnt  <= (state == ST_DRFSH);
        end
    end

    // ret_state remembers where an access or Z80 refresh cycle must return (IDLE, BREQ or DOWN)
    always_comb begin
        next_state = state;
        next_ret   = ret_state;
        case (state)
            ST_IDLE: begin
                if (z80_rfsh) begin
                    next_state = ST_RFSH;
                    next_ret   = ST_IDLE;
                end else if (mem_acc) begin
                    next_state = ST_ROW;
                    next_ret   = ST_IDLE;
                end else if (dma_req) begin
                    next_state = ST_BREQ;
                end
            end
            ST_ROW:  next_state = ST_COL;
            ST_COL:  next_state = ST_HOLD;
            ST_HOLD: if (BMREQ_N) next_state = ST_PRE;
            ST_RFSH: if (BMREQ_N) next_state = ST_PRE;
            ST_PRE:  next_state = ret_state;
            ST_BREQ: begin
                if (z80_rfsh) begin
                    next_state = ST_RFSH;
                    next_ret   = ST_BREQ;
                end else if (mem_acc) begin
                    next_state = ST_ROW;
                    next_ret   = ST_BREQ;
                end else if (!BUSAK_N) begin
                    next_state = ST_DOWN;
                end else if (!dma_req) begin
                    next_state = ST_BREL;
                end
            end
            ST_DOWN: begin
                if (mem_acc) begin
                    next_state = ST_ROW;
                    next_ret   = ST_DOWN;
                end else if (refresh_due) begin
                    next_state = ST_DRFSH;
                end else if (!dma_req) begin
                    next_state = ST_BREL;
                end
            end
            ST_DRFSH: if (rfsh_cnt) next_state = ST_DPRE;
            ST_DPRE:  next_state = ST_DOWN;
            ST_BREL:  if (BUSAK_N) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // DRAM strobes lag the state by one edge; bus handshake outputs follow the next state
    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            RAS_N       <= 1'b1;
            CAS1_N      <= 1'b1;
            CAS2_N      <= 1'b1;
            MUX         <= 1'b0;
            BUSRQ_N     <= 1'b1;
            ADDRBUFEN_N <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            RAS_N       <= !(state inside {ST_ROW, ST_COL, ST_HOLD, ST_RFSH, ST_DRFSH});
            CAS1_N      <= !(state == ST_HOLD && !bank);
            CAS2_N      <= !(state == ST_HOLD && bank);
            MUX         <= state inside {ST_COL, ST_HOLD};
            BUSRQ_N     <= !((next_state inside {ST_BREQ, ST_DOWN, ST_DRFSH, ST_DPRE}) ||
                             (is_access_state(next_state) && next_ret != ST_IDLE));
            ADDRBUFEN_N <= (next_state inside {ST_DOWN, ST_DRFSH, ST_DPRE, ST_BREL}) ||
                           (is_access_state(next_state) && next_ret == ST_DOWN);
            BUSY        <= (next_state != ST_IDLE);
        end
    end

`ifdef MIOC_DMA_REFRESH_EN
    localparam int TIMER_W = $clog2(REFRESH_PERIOD);
    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(REFRESH_PERIOD - 1);

    logic [TIMER_W-1:0]  timer;
    logic [ROW_BITS-1:0] ref_row_q;
    logic                counting;

    assign counting = state inside {ST_BREQ, ST_DOWN, ST_DRFSH, ST_DPRE, ST_BREL};
    assign REF_ROW  = ref_row_q;

    // Expiry has priority over the DPRE clear so a coincident expiry is not dropped
    always_ff @(posedge B_PHI or negedge RST_N) begin
        if (!RST_N) begin
            timer       <= RELOAD;
            refresh_due <= 1'b0;
            ref_row_q   <= '0;
            REF_OE      <= 1'b0;
        end else begin
            REF_OE <= (state == ST_DRFSH);
            if (state == ST_IDLE && next_state == ST_BREQ)
                timer <= RELOAD;
            else if (counting)
                timer <= (timer == '0) ? RELOAD : timer - 1'b1;
            if (counting && timer == '0)
                refresh_due <= 1'b1;
            else if (state == ST_DPRE)
                refresh_due <= 1'b0;
            if (state == ST_DPRE)
                ref_row_q <= ref_row_q + 1'b1;
        end
    end
`else
    assign refresh_due = 1'b0;
    assign REF_OE      = 1'b0;
    assign REF_ROW     = '0;
`endif

endmodule

// File: doc/mioc_dram_sched.md
# mioc_dram_sched

DRAM cycle sequencer and bus-ownership arbiter inside the MIOC. Generates RAS_N/MUX/CAS1_N/CAS2_N for Z80 memory and refresh cycles and for 6801 DMA cycles. Runs the BUSRQ_N/BUSAK_N handshake for DMA_N. While the Z80 is off the bus, it inserts its own RAS-only refresh. Sits between the buffered Z80 bus inputs and the DRAM strobe pins in mioc_top.

## Interface
- REFRESH_PERIOD, 54: B_PHI cycles between internal refresh requests while the Z80 is off the bus.
- ROW_BITS, 7: width of the internal refresh row counter.
- B_PHI  in  1  Z80 clock; all state updates on the rising edge.
- RST_N  in  1  System reset: asynchronous assert, active-low.
- BMREQ_N, BRD_N, N_BWR, BRFSH_N  in  1 each  Buffered bus strobes, active-low, synchronous to B_PHI.
- BA15  in  1  Bank select: 0 selects CAS1_N, 1 selects CAS2_N.
- RAM_LO_EN, RAM_HI_EN  in  1 each  From the memory-map decoder: RAM mapped in the lower / upper 32K.
- DMA_N  in  1  DMA request from the 6801, active-low, asynchronous to B_PHI.
- BUSAK_N  in  1  Z80 bus acknowledge, active-low.
- RAS_N, CAS1_N, CAS2_N  out  1 each  DRAM strobes, active-low.
- MUX  out  1  0 = row address, 1 = column address.
- BUSRQ_N  out  1  Z80 bus request, active-low.
- ADDRBUFEN_N  out  1  Z80 address buffer enable, active-low; driven high while DMA owns the bus.
- REF_OE  out  1  Drives REF_ROW onto the DRAM row address during an internal refresh.
- REF_ROW  out  ROW_BITS  Internal refresh row.
- BUSY  out  1  High whenever the FSM is not in IDLE.

## Operation
- DMA_N passes through a 2-flop synchronizer; the result is dma_req. All other inputs are used directly.
- FSM states: IDLE, ROW, COL, HOLD, PRE, RFSH, BREQ, DOWN, DRFSH, DPRE, BREL.
- From IDLE, checked in priority order:
  1. Z80 refresh: BMREQ_N=0 and BRFSH_N=0 → RFSH.
  2. Memory access: BMREQ_N=0, BRFSH_N=1, (BRD_N=0 or N_BWR=0), and the bank selected by BA15 is enabled → ROW.
  3. dma_req → BREQ.
- An unmapped-bank access is ignored and leaves the FSM in IDLE. No strobes fire.
- Access sequence: ROW (RAS_N=0) → COL (MUX=1) → HOLD (selected CAS=0, held until BMREQ_N=1) → PRE (all strobes inactive, MUX=0) → IDLE. The CAS bank is latched in ROW.
- RFSH: RAS_N=0 until BMREQ_N=1, then PRE. CAS stays inactive.
- BREQ: BUSRQ_N=0; wait for BUSAK_N=0, then → DOWN with ADDRBUFEN_N=1.
- DOWN: DMA memory accesses on BMREQ_N run the same ROW/COL/HOLD/PRE sequence and return to DOWN, not IDLE.
- DOWN, internal refresh: with no access pending and refresh_due set → DRFSH. In DRFSH, REF_OE=1 and RAS_N=0 for 2 cycles. Then DPRE for 1 cycle, REF_ROW increments, refresh_due clears, → DOWN.
- DOWN, release: dma_req=0 → BREL. BREL sets BUSRQ_N=1 and waits for BUSAK_N=1, then sets ADDRBUFEN_N=0 → IDLE.
- Refresh timer: counts only in BREQ, DOWN, DRFSH, DPRE and BREL. It reloads REFRESH_PERIOD-1 on entering BREQ. At zero it sets refresh_due, a single sticky flag; further expiries are lost.
- Z80 refresh cycles do not advance REF_ROW.

## Timing
- Reset values: RAS_N=CAS1_N=CAS2_N=1, MUX=0, BUSRQ_N=1, ADDRBUFEN_N=0, REF_OE=0, REF_ROW=0, BUSY=0, FSM in IDLE, refresh_due=0.
- All outputs are registered.
- Z80 access, counted from the edge that samples BMREQ_N=0 (edge 0): RAS_N low after edge 1, MUX high after edge 2, CAS low after edge 3. Release comes 1 edge after BMREQ_N=1 is sampled.
- DMA_N to BUSRQ_N=0: 3 edges when IDLE (2 for sync, 1 for the BREQ transition).
- DMA_N and BMREQ_N falling on the same edge: the memory cycle completes first, then BREQ.
- A Z80 access arriving in BREQ before BUSAK_N=0 is serviced; BREQ resumes afterwards.
- RST_N low mid-cycle forces all outputs to their reset values immediately, including releasing BUSRQ_N.
- REF_ROW wraps from 2^ROW_BITS-1 to 0.

## Configuration
- MIOC_DMA_REFRESH_EN defined: the refresh timer, the DRFSH/DPRE states and REF_ROW are built.
- MIOC_DMA_REFRESH_EN undefined: no timer; DOWN never enters DRFSH; REF_OE is tied 0 and REF_ROW is tied 0.

## Structure
- Shared mioc_pkg holds the FSM state enum, DEFAULT_REFRESH_PERIOD and REF_ROW_BITS.
- One sub-module, mioc_sync2: the 2-flop synchronizer, reused for DMA_N and available to other MIOC blocks.
- The FSM, bank latch and refresh timer stay in mioc_dram_sched.

## Test plan
- Reset: RST_N=0 → all outputs at reset values. Release → BUSY=0.
- Read, BA15=0, RAM_LO_EN=1 → RAS_N low after edge 1, MUX high after edge 2, CAS1_N low after edge 3. CAS2_N stays 1 throughout.
- Z80 refresh, BMREQ_N=0 and BRFSH_N=0 → RAS_N pulse only. Both CAS stay 1. REF_ROW unchanged.
- DMA_N=0 with BUSAK_N returned 2 cycles after BUSRQ_N → BUSRQ_N=0 after edge 3, ADDRBUFEN_N=1 once BUSAK_N=0. Hold 200 cycles with REFRESH_PERIOD=54 → 3 DRFSH cycles, REF_ROW=3.
- DMA_N and BMREQ_N falling on the same edge (BA15=1, RAM_HI_EN=1) → CAS2_N cycle completes first, then BUSRQ_N=0.
- Assert RST_N in HOLD → CAS and RAS return to 1 immediately, no glitch at deassert.
